// File: rtl/sramgen_sram_model_v2.sv
// Parametrised behavioural SRAM with byte-lane write mask, pipelined read port
// and a post-reset sweep that zeroes the array before requests are accepted.
module sramgen_sram_model_v2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   init_done
);

  // state    | meaning
  // ST_CLEAR | sweeping zeros into the array (or one-edge pass-through), no requests
  // ST_READY | accepting one request per edge, no backpressure

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be within 1..4");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    clr_we;
  logic                    rd_acc;
  logic                    wr_acc;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [READ_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    clr_we     = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = (INIT_CLEAR != 0);
        if (INIT_CLEAR == 0 || cnt == {ADDR_WIDTH{1'b1}}) state_next = ST_READY;
      end
      ST_READY: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  assign rd_acc = req_valid & req_ready & ~we;
  assign wr_acc = req_valid & req_ready & we;

  // Array is deliberately not reset; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < WMASK_WIDTH; k++) begin
        if (wmask[k]) mem[addr][k*LANE_WIDTH +: LANE_WIDTH] <= din[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Each stage only loads when its input is valid, so the last stage holds the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= mem[addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign dout       = pd[READ_LATENCY-1];
  assign dout_valid = pv[READ_LATENCY-1];

endmodule
